serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand set offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  addend A.
REQ-007 SHALL have port: b  input  WIDTH  addend B.
REQ-008 SHALL have port: carry_in  input  1  initial carry.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: sum_output  output  WIDTH  result sum.
REQ-012 SHALL have port: carry_out  output  1  final carry.
REQ-013 SHALL have port: busy  output  1  high in SHIFT or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL accept operands when in_valid and in_ready are both high on a clk edge: latch a, b, carry_in; bit counter cleared; go to SHIFT.
REQ-016 SHALL drive in_ready high only in IDLE.
REQ-017 SHALL, in SHIFT, each cycle add the LSB of shifted A, shifted B and the carry flop through one full-adder slice, shift the sum bit into the result register MSB-first, and update the carry flop.
REQ-018 SHALL stay in SHIFT exactly WIDTH cycles, then go to DONE; out_valid rises WIDTH+1 edges after the accept edge.
REQ-019 SHALL hold sum_output, carry_out and out_valid stable in DONE until out_ready is high on a clk edge; then go to IDLE.
REQ-020 SHALL ignore in_valid while busy; operands changing during SHIFT/DONE have no effect.
REQ-021 SHALL NOT support back-to-back overlap; the minimum accept-to-accept interval is WIDTH+2 cycles.
REQ-022 SHALL produce sum_output = (a + b + carry_in) mod 2^WIDTH and carry_out = bit WIDTH of that sum.
REQ-023 SHALL keep sum_output/carry_out from the last transaction while in IDLE.

Reset
REQ-024 SHALL, on rst_n low, immediately enter IDLE: in_ready=1, out_valid=0, busy=0, sum_output=0, carry_out=0, counter and carry flop 0.
REQ-025 SHALL abort any transaction in progress on reset with no partial result visible; first accept is possible on the first edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro SERIAL_ADDER_SUB_EN defined, add input port sub (1 bit, latched at accept); when sub=1 the block computes a - b by using ~b and forcing the initial carry to 1, ignoring carry_in; carry_out=1 means no borrow.
REQ-027 SHALL, without SERIAL_ADDER_SUB_EN, have no sub port and addition-only behaviour.

Structure
REQ-028 SHALL place FSM state encodings (IDLE=0, SHIFT=1, DONE=2) and the default WIDTH constant in shared package serial_adder_pkg.
REQ-029 SHALL instantiate the existing fulladder module as its single sub-module for the per-bit slice; no other arithmetic operators on operand bits.

Verification
REQ-030 SHALL cover: WIDTH=8, a=3, b=5, carry_in=0 -> out_valid on edge 9 after accept, sum_output=8, carry_out=0.
REQ-031 SHALL cover: a=255, b=0, carry_in=1 -> sum_output=0, carry_out=1 (full ripple wrap).
REQ-032 SHALL cover: out_ready held low 5 cycles after out_valid -> outputs stable, in_ready=0 throughout; accept next operands only after handshake.
REQ-033 SHALL cover: rst_n pulsed low at SHIFT cycle 4 -> out_valid never asserts, outputs 0, in_ready=1 immediately.
REQ-034 SHALL cover: with SERIAL_ADDER_SUB_EN, sub=1, a=5, b=7 -> sum_output=8'hFE, carry_out=0; a=7, b=5 -> sum_output=2, carry_out=1.
REQ-035 SHALL cover: all 8 (a[0], b[0], carry_in) combinations with other bits 0 -> results match a+b+carry_in.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, the default
// operand width and a helper that sizes the bit counter.
package serial_adder_pkg;

  // Default operand width in bits (legal range 2..32).
  localparam int SA_DEFAULT_WIDTH = 8;

  // Controller states. Encodings are fixed so that the values seen in
  // simulation or on a debug probe match the documented ones.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sa_state_t;

  // Counter width able to hold the index of the last bit (WIDTH-1).
  // Never returns less than one bit so narrow builds still have a counter.
  function automatic int sa_cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/fulladder.sv
// One-bit full adder slice: sum and carry of two operand bits plus carry-in.
// Used by serial_adder as its only arithmetic element.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Pure combinational sum / majority carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule : fulladder

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts a WIDTH-bit operand pair plus carry, processes one
// bit per clock through a single full-adder slice, then presents the result
// with a valid/ready handshake.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input. When sub
// is high at accept, the block computes a - b (two's complement: ~b with the
// initial carry forced to 1, carry_in ignored); carry_out=1 then means no
// borrow. Without the macro the block is addition-only and has no sub port.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_output,
  output logic             carry_out,
  output logic             busy
);

  localparam int             CNT_W    = sa_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  sa_state_t          r_state;
  sa_state_t          w_state_next;

  logic [WIDTH-1:0]   r_a;        // addend A, shifted right one bit per cycle
  logic [WIDTH-1:0]   r_b;        // addend B (or ~B), shifted the same way
  logic               r_carry;    // running carry between bit slices
  logic [CNT_W-1:0]   r_cnt;      // index of the bit being processed
  logic [WIDTH-2:0]   r_acc;      // partial result, bits arrive at the MSB end

  logic [WIDTH-1:0]   r_sum;      // committed result, visible on sum_output
  logic               r_cout;     // committed final carry

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic               w_accept;
  logic               w_shifting;
  logic               w_last_bit;
  logic               w_sum_bit;
  logic               w_carry_bit;
  logic [WIDTH-1:0]   w_acc_shift;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_carry_load;

  // Operand conditioning at accept time. Subtraction reuses the adder by
  // inverting B and injecting a carry of one, so the serial datapath is the
  // same in both modes.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load     = sub ? ~b : b;
  assign w_carry_load = sub ? 1'b1 : carry_in;
`else
  assign w_b_load     = b;
  assign w_carry_load = carry_in;
`endif

  // Handshake qualifiers and end-of-operand detection.
  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_shifting = (r_state == ST_SHIFT);
  assign w_last_bit = (r_cnt == CNT_LAST);

  // The new sum bit enters at the MSB; after WIDTH shifts the first bit
  // computed (the LSB) has walked down to bit 0.
  assign w_acc_shift = {w_sum_bit, r_acc};

  // The only arithmetic element: one full-adder slice on the operand LSBs.
  fulladder u_fulladder (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_sum_bit),
    .cout (w_carry_bit)
  );

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register; reset forces IDLE immediately, aborting any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> SHIFT on accept, SHIFT for WIDTH cycles,
  // DONE until the consumer takes the result.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_bit) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from the current state only, so handshake outputs are glitch
  // free with respect to the inputs.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_SHIFT: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------

  // Operand capture at accept, then one-bit right shift per SHIFT cycle with
  // the carry flop fed back from the slice. Inputs are ignored while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_carry <= w_carry_load;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_shifting) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_carry <= w_carry_bit;
      r_cnt   <= r_cnt + CNT_W'(1);
      r_acc   <= w_acc_shift[WIDTH-1:1];
    end
  end

  // Result commit on the last bit only, so a partial sum is never visible and
  // the previous result persists through IDLE and the next SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_shifting && w_last_bit) begin
      r_sum  <= w_acc_shift;
      r_cout <= w_carry_bit;
    end
  end

  assign sum_output = r_sum;
  assign carry_out  = r_cout;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). Expected results come from a
// behavioural model, are queued when operands are offered and compared when
// the DUT presents out_valid. Subtraction cases run when SERIAL_ADDER_SUB_EN
// is defined.
module tb_serial_adder;

  localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         carry_in  = 1'b0;
  logic         sub       = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic         carry_out;
  logic         busy;
  logic [W-1:0] sum_output;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub        (sub),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum_output (sum_output),
    .carry_out  (carry_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic, independent of the serial implementation.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    logic [W:0] t;
    exp_t       r;
    if (ms) begin
      t = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
    end else begin
      t = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
    end
    r.sum  = t[W-1:0];
    r.cout = t[W];
    return r;
  endfunction

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for in_ready; an expired bound is reported as a failed check.
  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // One full transaction: offer, observe latency and busy behaviour, hold the
  // result for 'hold' cycles with out_ready low, then complete the handshake.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic ts, input int hold);
    int   lat;
    exp_t e;
    wait_ready();
    a        = ta;
    b        = tb_;
    carry_in = tc;
    sub      = ts;
    in_valid = 1'b1;
    sb.push_back(model(ta, tb_, tc, ts & SUB_ON));
    tick();                           // accept edge
    in_valid = 1'b0;
    a        = W'($urandom);          // operands change while busy
    b        = W'($urandom);
    carry_in = 1'($urandom);
    sub      = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_while_busy", 32'(in_ready), 32'd0);
    in_valid = 1'b1;                  // must be ignored while busy
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    // lat = edges after the accept edge until out_valid is seen (accept edge
    // counted as edge 1, so out_valid appears on edge WIDTH+1).
    check("out_valid_rise", 32'(out_valid), 32'd1);
    check("latency", 32'(lat), 32'(W));
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_sum", 32'(sum_output), 32'(e.sum));
      check("hold_cout", 32'(carry_out), 32'(e.cout));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    check("sum", 32'(sum_output), 32'(e.sum));
    check("carry_out", 32'(carry_out), 32'(e.cout));
    $display("txn a=%02h b=%02h cin=%0d sub=%0d hold=%0d -> sum=%02h cout=%0d (model %02h/%0d) lat=%0d",
             ta, tb_, tc, ts & SUB_ON, hold, sum_output, carry_out, e.sum, e.cout, lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_keep_sum", 32'(sum_output), 32'(e.sum));
    check("idle_keep_cout", 32'(carry_out), 32'(e.cout));
  endtask

  // Abort a transaction with reset during SHIFT cycle 4; outputs must clear
  // immediately and the next accept happens on the first edge after release.
  task automatic reset_abort();
    wait_ready();
    a        = 8'hC3;
    b        = 8'h7E;
    carry_in = 1'b1;
    sub      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum_output), 32'd0);
    check("rst_cout", 32'(carry_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_valid", 32'(out_valid), 32'd0);
    end
    #3 rst_n = 1'b1;
    $display("txn reset abort during SHIFT, outputs cleared");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] v;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sum", 32'(sum_output), 32'd0);
    check("reset_cout", 32'(carry_out), 32'd0);
    rst_n = 1'b1;

    run_txn(8'd3, 8'd5, 1'b0, 1'b0, 0);
    run_txn(8'd255, 8'd0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      run_txn(W'(v[2]), W'(v[1]), v[0], 1'b0, 0);
    end
    run_txn(8'hA7, 8'h5C, 1'b1, 1'b0, 5);
    reset_abort();
    run_txn(8'h80, 8'h80, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      run_txn(W'($urandom), W'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 3)));
    end
`ifdef SERIAL_ADDER_SUB_EN
    run_txn(8'd5, 8'd7, 1'b0, 1'b1, 1);
    run_txn(8'd7, 8'd5, 1'b0, 1'b1, 0);
    run_txn(8'd7, 8'd5, 1'b1, 1'b1, 0);
    run_txn(8'd9, 8'd9, 1'b0, 1'b1, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_serial_adder
